// File: rtl/alu_exec_unit_if.sv
// Issue/result handshake bundle for the multicycle ALU execution unit.
// The master issues operations and consumes results; the unit is the slave.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, ALUControl, a, b, kill, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, ALUControl, a, b, kill, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multicycle ALU execute unit: single-cycle logic ops, bit-serial shifts,
// registered result/zero behind valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_exec_unit_if.slave bus
);
    localparam int SMAX = (WIDTH - 1 > 31) ? 31 : WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             in_ready;
    logic             accept;
    logic             is_shift;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;

    assign in_ready = (state_q == IDLE) && reset_n;
    assign accept   = bus.in_valid && in_ready && !bus.kill;
    assign is_shift = bus.ALUControl[2] && bus.ALUControl[1];
    assign shamt    = (bus.b[4:0] > 5'(SMAX)) ? 5'(SMAX) : bus.b[4:0];
    // dir_q high selects a logical right shift
    assign acc_step = dir_q ? (acc_q >> 1) : (acc_q << 1);

    always_comb begin
        alu_res = '0;
        unique case (bus.ALUControl)
            3'b000: alu_res = bus.a + bus.b;
            3'b001: alu_res = bus.a - bus.b;
            3'b010: alu_res = bus.a & bus.b;
            3'b011: alu_res = bus.a | bus.b;
            3'b100: alu_res = bus.a ^ bus.b;
            3'b101: alu_res = {{(WIDTH-1){1'b0}},
                               $signed(bus.a) < $signed(bus.b)};
            3'b110: alu_res = bus.a;
            3'b111: alu_res = bus.a;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (accept)
                           state_d = (is_shift && shamt != 5'd0) ? SHIFT : DONE;
                SHIFT: if (cnt_q == 5'd1) state_d = DONE;
                DONE:  if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (accept) begin
            if (is_shift && shamt != 5'd0) begin
                acc_d = bus.a;
                cnt_d = shamt;
                dir_d = bus.ALUControl[0];
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
            end
        end else if (state_q == SHIFT && !bus.kill) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                result_d = acc_step;
                zero_d   = (acc_step == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a plain
// arithmetic reference model of the op set and shift latency.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    function automatic int eff_shamt(input logic [31:0] b);
        int s;
        s = int'(b % 32);
        if (s > W - 1) s = W - 1;
        return s;
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = eff_shamt(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << s;
            default: return a >> s;
        endcase
    endfunction

    // cycles between the accept edge and the edge that raises out_valid
    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] b);
        if (op >= 3'd6 && eff_shamt(b) > 0) return eff_shamt(b);
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output bit busy_ok);
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
        bus.ALUControl = 3'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 64) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.in_valid   = 1'b1;
        bus.ALUControl = 3'd0;
        bus.a          = 32'd1;
        bus.b          = 32'd1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got %h want 0", bus.result);
        end
        vectors++;
        if (bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero got %b want 0", bus.zero);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  ops [3] = '{3'd1, 3'd5, 3'd0};
        logic [31:0] as  [3] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'd5, 32'd1, 32'd1};
        logic [31:0] exp_r;
        int  lat;
        bit  busy_ok;
        for (int i = 0; i < 3; i++) begin
            exp_r = model_res(ops[i], as[i], bs[i]);
            issue(ops[i], as[i], bs[i], lat, busy_ok);
            vectors++;
            if (lat !== 0) begin
                errors++;
                $display("FAIL op%0d_latency got %0d want 0", i, lat);
            end
            vectors++;
            if (bus.result !== exp_r || bus.zero !== (exp_r == 0)) begin
                errors++;
                $display("FAIL op%0d_result got %h/%b want %h/%b", i,
                         bus.result, bus.zero, exp_r, exp_r == 0);
            end
            drain();
        end
    endtask

    task automatic test_shift_latency();
        logic [2:0]  ops [3] = '{3'd6, 3'd7, 3'd6};
        logic [31:0] as  [3] = '{32'd1, 32'h8000_0000, 32'd1};
        logic [31:0] bs  [3] = '{32'd31, 32'd0, 32'h25};
        int  want_lat [3] = '{31, 0, 5};
        logic [31:0] want_r [3] = '{32'h8000_0000, 32'h8000_0000, 32'h20};
        int  lat;
        bit  busy_ok;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], lat, busy_ok);
            vectors++;
            if (lat !== want_lat[i] || !busy_ok) begin
                errors++;
                $display("FAIL shift%0d_latency got %0d busy_ok=%b want %0d",
                         i, lat, busy_ok, want_lat[i]);
            end
            vectors++;
            if (bus.result !== want_r[i]) begin
                errors++;
                $display("FAIL shift%0d_result got %h want %h", i,
                         bus.result, want_r[i]);
            end
            drain();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp_r;
        int  lat;
        bit  busy_ok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            exp_r = model_res(op, a, b);
            issue(op, a, b, lat, busy_ok);
            vectors++;
            if (lat !== model_lat(op, b) || !busy_ok) begin
                errors++;
                $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i,
                         op, lat, model_lat(op, b));
            end
            vectors++;
            if (bus.result !== exp_r || bus.zero !== (exp_r == 0)) begin
                errors++;
                $display("FAIL rand%0d_result op=%0d got %h/%b want %h/%b",
                         i, op, bus.result, bus.zero, exp_r, exp_r == 0);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r;
        int  lat;
        bit  busy_ok;
        exp_r = 32'hF0F0_1234 & 32'hFF00_FF00;
        issue(3'd2, 32'hF0F0_1234, 32'hFF00_FF00, lat, busy_ok);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== exp_r) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%b res=%h want 1 0 %h",
                         i, bus.out_valid, bus.in_ready, bus.result, exp_r);
            end
            @(negedge clk);
        end
        drain();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b r=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        int  lat;
        bit  busy_ok;
        bit  seen;
        prev = model_res(3'd0, 32'd7, 32'd8);
        issue(3'd0, 32'd7, 32'd8, lat, busy_ok);
        drain();
        bus.ALUControl = 3'd7;
        bus.a          = $urandom | 32'h8000_0000;
        bus.b          = 32'd20;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.result !== prev) begin
            errors++;
            $display("FAIL kill_shift got v=%b r=%b res=%h want 0 1 %h",
                     bus.out_valid, bus.in_ready, bus.result, prev);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL kill_no_valid got out_valid=1 want 0");
        end
        bus.ALUControl = 3'd0;
        bus.a          = 32'd1;
        bus.b          = 32'd1;
        bus.in_valid   = 1'b1;
        bus.kill       = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.result !== prev) begin
            errors++;
            $display("FAIL kill_accept got v=%b r=%b res=%h want 0 1 %h",
                     bus.out_valid, bus.in_ready, bus.result, prev);
        end
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  busy_ok;
        bus.ALUControl = 3'd6;
        bus.a          = 32'd1;
        bus.b          = 32'd31;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 ||
            bus.zero !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_shift got v=%b res=%h z=%b r=%b want 0 0 0 0",
                     bus.out_valid, bus.result, bus.zero, bus.in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, lat, busy_ok);
        vectors++;
        if (lat !== 0 || bus.result !== 32'd7) begin
            errors++;
            $display("FAIL rst_shift_next got lat=%0d res=%h want 0 7",
                     lat, bus.result);
        end
        drain();
        issue(3'd3, 32'h55, 32'hAA0, lat, busy_ok);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 ||
            bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got v=%b res=%h z=%b want 0 0 0",
                     bus.out_valid, bus.result, bus.zero);
        end
        reset_n = 1'b1;
        @(negedge clk);
        issue(3'd6, 32'd1, 32'd3, lat, busy_ok);
        vectors++;
        if (lat !== 3 || !busy_ok || bus.result !== 32'd8) begin
            errors++;
            $display("FAIL rst_done_next got lat=%0d res=%h want 3 8",
                     lat, bus.result);
        end
        drain();
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.kill       = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ALUControl = 3'd0;
        bus.a          = '0;
        bus.b          = '0;
        test_reset();
        test_alu_ops();
        test_shift_latency();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
